cve2_pmp_csr: RTL

CVE2_PMP_CSR -- requirements
Module: cve2_pmp_csr

---
 rtl/cve2_pmp_csr.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/cve2_pmp_csr.sv
// PMP control/status register block.
//
// Holds the PMP region configuration (pmpcfg0-3), region addresses
// (pmpaddr0-15) and the machine security configuration (mseccfg), and
// feeds them straight from state to the PMP checker. It takes one access
// per cycle and answers each one exactly one cycle later.
//
// Ports
//   clk_i, rst_ni      clock, synchronous active-low reset
//   csr_req_i          one-cycle access request
//   csr_we_i           1 = write, 0 = read
//   csr_addr_i         12-bit CSR address
//   csr_wdata_i        write data
//   csr_valid_o        response valid (one cycle after the request)
//   csr_rdata_o        read data (pre-write value for writes)
//   csr_err_o          illegal CSR address
//   csr_pmp_cfg_o      per-region configuration
//   csr_pmp_addr_o     per-region address, {pmpaddr, 2'b00}
//   csr_pmp_mseccfg_o  MML / MMWP / RLB

package cve2_pmp_csr_pkg;

  localparam logic [1:0] PMP_OFF   = 2'b00;
  localparam logic [1:0] PMP_TOR   = 2'b01;
  localparam logic [1:0] PMP_NA4   = 2'b10;
  localparam logic [1:0] PMP_NAPOT = 2'b11;

  typedef struct packed {
    logic       lock;
    logic [1:0] mode;
    logic       exec;
    logic       write;
    logic       read;
  } pmp_cfg_t;

  typedef struct packed {
    logic rlb;
    logic mmwp;
    logic mml;
  } pmp_mseccfg_t;

endpackage

module cve2_pmp_csr
  import cve2_pmp_csr_pkg::*;
#(
  parameter int PMPGranularity = 0,
  parameter int PMPNumRegions  = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         csr_req_i,
  input  logic         csr_we_i,
  input  logic [11:0]  csr_addr_i,
  input  logic [31:0]  csr_wdata_i,
  output logic         csr_valid_o,
  output logic [31:0]  csr_rdata_o,
  output logic         csr_err_o,
  output pmp_cfg_t     csr_pmp_cfg_o [PMPNumRegions],
  output logic [33:0]  csr_pmp_addr_o [PMPNumRegions],
  output pmp_mseccfg_t csr_pmp_mseccfg_o
);

  pmp_cfg_t     cfg_q  [PMPNumRegions];
  pmp_cfg_t     cfg_d  [PMPNumRegions];
  logic [31:0]  addr_q [PMPNumRegions];
  logic [31:0]  addr_d [PMPNumRegions];
  pmp_mseccfg_t msec_q;
  pmp_mseccfg_t msec_d;

  logic         vld_p1;
  logic [31:0]  rdata_p1;
  logic         err_p1;

  // Full 16-entry views so the read mux can index any region number;
  // unimplemented regions appear as all-zero.
  pmp_cfg_t     cfg_all  [16];
  logic [31:0]  addr_all [16];

  logic [PMPNumRegions-1:0] lock_vec;
  logic [PMPNumRegions-1:0] addr_lock;

  logic        sel_cfg, sel_addr, sel_msec, sel_msech, legal, wr_en;
  logic [31:0] rdata_d;

  // Byte image of a region configuration; bits [6:5] always read zero.
  function automatic logic [7:0] cfg_byte(input pmp_cfg_t c);
    return {c.lock, 2'b00, c.mode, c.exec, c.write, c.read};
  endfunction

  // WARL legalisation of a written configuration byte.
  function automatic pmp_cfg_t cfg_legal(input logic [7:0] b, input pmp_cfg_t old,
                                         input logic mml);
    pmp_cfg_t n;
    n.lock  = b[7];
    n.mode  = b[4:3];
    n.exec  = b[2];
    n.write = b[1];
    n.read  = b[0];
    // Write-only is a reserved encoding outside machine-mode lockdown.
    if (!mml && !b[0] && b[1]) n.write = 1'b0;
    // NA4 cannot be represented once the granule is larger than 4 bytes.
    if (PMPGranularity >= 1 && b[4:3] == PMP_NA4) n.mode = old.mode;
    return n;
  endfunction

  // Whether a configuration byte write is allowed to land at all.
  function automatic logic cfg_wr_ok(input pmp_cfg_t old, input logic [7:0] b,
                                     input pmp_mseccfg_t sec);
    if (old.lock && !sec.rlb) return 1'b0;
    // Under MML, locking in an executable or write-only rule would create a
    // machine-mode-only permission that could never be revoked.
    if (sec.mml && !sec.rlb && b[7] && !old.lock && (b[2] || (!b[0] && b[1])))
      return 1'b0;
    return 1'b1;
  endfunction

  // Granularity view of a stored address; the stored bits are untouched.
  function automatic logic [31:0] addr_rd(input logic [31:0] a, input logic [1:0] mode);
    logic [31:0] v;
    v = a;
    for (int b = 0; b < 32; b++) begin
      if (PMPGranularity >= 1) begin
        if (mode == PMP_NAPOT && b + 1 < PMPGranularity) v[b] = 1'b1;
        else if (!mode[1] && b < PMPGranularity) v[b] = 1'b0;
      end
    end
    return v;
  endfunction

  for (genvar r = 0; r < 16; r++) begin : g_all
    if (r < PMPNumRegions) begin : g_impl
      assign cfg_all[r]  = cfg_q[r];
      assign addr_all[r] = addr_q[r];
    end else begin : g_none
      assign cfg_all[r]  = '0;
      assign addr_all[r] = '0;
    end
  end

  // An address is frozen by its own lock, or by a locked TOR region above
  // it that uses this address as its lower bound.
  for (genvar r = 0; r < PMPNumRegions; r++) begin : g_lock
    assign lock_vec[r] = cfg_q[r].lock;
    if (r + 1 < PMPNumRegions) begin : g_tor
      assign addr_lock[r] = ~msec_q.rlb &
                            (cfg_q[r].lock | (cfg_q[r+1].lock & (cfg_q[r+1].mode == PMP_TOR)));
    end else begin : g_top
      assign addr_lock[r] = ~msec_q.rlb & cfg_q[r].lock;
    end
    assign csr_pmp_cfg_o[r]  = cfg_q[r];
    assign csr_pmp_addr_o[r] = {addr_q[r], 2'b00};
  end

  assign csr_pmp_mseccfg_o = msec_q;

  assign sel_cfg   = (csr_addr_i[11:2] == 10'h0E8);
  assign sel_addr  = (csr_addr_i[11:4] == 8'h3B);
  assign sel_msec  = (csr_addr_i == 12'h747);
  assign sel_msech = (csr_addr_i == 12'h757);
  assign legal     = sel_cfg | sel_addr | sel_msec | sel_msech;
  assign wr_en     = csr_req_i & csr_we_i & legal;

  always_comb begin : read_mux
    rdata_d = '0;
    if (sel_cfg) begin
      for (int i = 0; i < 4; i++)
        rdata_d[i*8 +: 8] = cfg_byte(cfg_all[{csr_addr_i[1:0], 2'(i)}]);
    end else if (sel_addr) begin
      rdata_d = addr_rd(addr_all[csr_addr_i[3:0]], cfg_all[csr_addr_i[3:0]].mode);
    end else if (sel_msec) begin
      rdata_d = {29'b0, msec_q};
    end
  end

  always_comb begin : next_state
    for (int r = 0; r < PMPNumRegions; r++) begin
      cfg_d[r]  = cfg_q[r];
      addr_d[r] = addr_q[r];
    end
    msec_d = msec_q;
    if (wr_en && sel_cfg) begin
      for (int r = 0; r < PMPNumRegions; r++) begin
        if (2'(r / 4) == csr_addr_i[1:0] &&
            cfg_wr_ok(cfg_q[r], csr_wdata_i[(r % 4) * 8 +: 8], msec_q))
          cfg_d[r] = cfg_legal(csr_wdata_i[(r % 4) * 8 +: 8], cfg_q[r], msec_q.mml);
      end
    end
    if (wr_en && sel_addr) begin
      for (int r = 0; r < PMPNumRegions; r++) begin
        if (csr_addr_i[3:0] == 4'(r) && !addr_lock[r]) addr_d[r] = csr_wdata_i;
      end
    end
    if (wr_en && sel_msec) begin
      msec_d.mml  = msec_q.mml  | csr_wdata_i[0];
      msec_d.mmwp = msec_q.mmwp | csr_wdata_i[1];
      msec_d.rlb  = csr_wdata_i[2] & (msec_q.rlb | ~(|lock_vec));
    end
  end

  // Stage p1: response and committed state
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
      err_p1   <= 1'b0;
      msec_q   <= '0;
      for (int r = 0; r < PMPNumRegions; r++) begin
        cfg_q[r]  <= '0;
        addr_q[r] <= '0;
      end
    end else begin
      vld_p1   <= csr_req_i;
      rdata_p1 <= (csr_req_i && legal) ? rdata_d : '0;
      err_p1   <= csr_req_i & ~legal;
      msec_q   <= msec_d;
      for (int r = 0; r < PMPNumRegions; r++) begin
        cfg_q[r]  <= cfg_d[r];
        addr_q[r] <= addr_d[r];
      end
    end
  end

  assign csr_valid_o = vld_p1;
  assign csr_rdata_o = rdata_p1;
  assign csr_err_o   = err_p1;

endmodule
